// File: rtl/plru_set_tracker.sv
// Per-set tree pseudo-LRU state for the L1D: victim lookups with one-cycle latency,
// MRU marking on touch (hit) and alloc (refill), and write-first bypass to lookups.
module plru_set_tracker #(
  parameter int NSET  = 64,
  parameter int NWAY  = 8,
  parameter int IDX_W = $clog2(NSET),
  parameter int WAY_W = $clog2(NWAY),
  parameter int LRU_W = NWAY - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lkp_vld_i,
  input  logic [IDX_W-1:0] lkp_idx_i,
  input  logic [NWAY-1:0]  lkp_inv_mask_i,
  output logic             victim_vld_o,
  output logic [WAY_W-1:0] victim_way_o,
  output logic [LRU_W-1:0] victim_lru_o,
  input  logic             touch_vld_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             alloc_vld_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [WAY_W-1:0] alloc_way_i
);

  logic [NSET-1:0][LRU_W-1:0] lruMem_q;
  logic                       victimVld_q;
  logic [WAY_W-1:0]           victimWay_q;
  logic [LRU_W-1:0]           victimLru_q;

  logic [LRU_W-1:0] allocTree_d;
  logic [LRU_W-1:0] touchBase_d;
  logic [LRU_W-1:0] touchTree_d;
  logic [LRU_W-1:0] lkpTree_d;
  logic [WAY_W-1:0] victimWay_d;

  // idx tracks (heap node - 1); each node points away from the way's path
  function automatic logic [LRU_W-1:0] markMru(input logic [LRU_W-1:0] tree,
                                               input logic [WAY_W-1:0] way);
    logic [LRU_W-1:0] t;
    logic [WAY_W-1:0] idx;
    logic [WAY_W-1:0] w;
    logic             b;
    t   = tree;
    idx = '0;
    w   = way;
    for (int k = 0; k < WAY_W; k++) begin
      b      = w[WAY_W-1];
      t[idx] = ~b;
      idx    = WAY_W'(2 * int'(idx) + 1 + int'(b));
      w      = w << 1;
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] treeWalk(input logic [LRU_W-1:0] tree);
    logic [WAY_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic             b;
    idx = '0;
    way = '0;
    for (int k = 0; k < WAY_W; k++) begin
      b   = tree[idx];
      way = (way << 1) | WAY_W'(b);
      idx = WAY_W'(2 * int'(idx) + 1 + int'(b));
    end
    return way;
  endfunction

  function automatic logic [WAY_W-1:0] lowestSet(input logic [NWAY-1:0] mask);
    logic [NWAY-1:0]  m;
    logic [WAY_W-1:0] way;
    logic             found;
    m     = mask;
    way   = '0;
    found = 1'b0;
    for (int i = 0; i < NWAY; i++) begin
      if (m[0] && !found) begin
        way   = WAY_W'(i);
        found = 1'b1;
      end
      m = m >> 1;
    end
    return way;
  endfunction

  // Alloc lands first, touch is layered on top when both hit one set
  always_comb begin
    allocTree_d = markMru(lruMem_q[alloc_idx_i], alloc_way_i);
    touchBase_d = lruMem_q[touch_idx_i];
    if (alloc_vld_i && (alloc_idx_i == touch_idx_i)) touchBase_d = allocTree_d;
    touchTree_d = markMru(touchBase_d, touch_way_i);

    lkpTree_d = lruMem_q[lkp_idx_i];
    if (alloc_vld_i && (alloc_idx_i == lkp_idx_i)) lkpTree_d = allocTree_d;
    if (touch_vld_i && (touch_idx_i == lkp_idx_i)) lkpTree_d = touchTree_d;

    victimWay_d = (|lkp_inv_mask_i) ? lowestSet(lkp_inv_mask_i) : treeWalk(lkpTree_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lruMem_q <= '0;
    end else begin
      if (alloc_vld_i) lruMem_q[alloc_idx_i] <= allocTree_d;
      if (touch_vld_i) lruMem_q[touch_idx_i] <= touchTree_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victimVld_q <= 1'b0;
      victimWay_q <= '0;
      victimLru_q <= '0;
    end else begin
      victimVld_q <= lkp_vld_i;
      if (lkp_vld_i) begin
        victimWay_q <= victimWay_d;
        victimLru_q <= lkpTree_d;
      end
    end
  end

  assign victim_vld_o = victimVld_q;
  assign victim_way_o = victimWay_q;
  assign victim_lru_o = victimLru_q;

endmodule

// File: tb/tb_plru_set_tracker.sv
// Directed vector table, a mid-operation reset sequence and a model-checked random
// soak for plru_set_tracker (NSET=64, NWAY=8).
module tb_plru_set_tracker;

  localparam int NSET  = 64;
  localparam int NWAY  = 8;
  localparam int IDX_W = 6;
  localparam int WAY_W = 3;
  localparam int LRU_W = 7;

  logic             clk;
  logic             rst_n;
  logic             lkpVld;
  logic [IDX_W-1:0] lkpIdx;
  logic [NWAY-1:0]  lkpMask;
  logic             victimVld;
  logic [WAY_W-1:0] victimWay;
  logic [LRU_W-1:0] victimLru;
  logic             touchVld;
  logic [IDX_W-1:0] touchIdx;
  logic [WAY_W-1:0] touchWay;
  logic             allocVld;
  logic [IDX_W-1:0] allocIdx;
  logic [WAY_W-1:0] allocWay;

  int errors = 0;
  int checks = 0;

  plru_set_tracker #(.NSET(NSET), .NWAY(NWAY)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lkp_vld_i      (lkpVld),
    .lkp_idx_i      (lkpIdx),
    .lkp_inv_mask_i (lkpMask),
    .victim_vld_o   (victimVld),
    .victim_way_o   (victimWay),
    .victim_lru_o   (victimLru),
    .touch_vld_i    (touchVld),
    .touch_idx_i    (touchIdx),
    .touch_way_i    (touchWay),
    .alloc_vld_i    (allocVld),
    .alloc_idx_i    (allocIdx),
    .alloc_way_i    (allocWay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             tVld;
    logic [IDX_W-1:0] tIdx;
    logic [WAY_W-1:0] tWay;
    logic             aVld;
    logic [IDX_W-1:0] aIdx;
    logic [WAY_W-1:0] aWay;
    logic             lVld;
    logic [IDX_W-1:0] lIdx;
    logic [NWAY-1:0]  mask;
    logic             eVld;
    logic [WAY_W-1:0] eWay;
    logic [LRU_W-1:0] eLru;
  } vec_t;

  function automatic vec_t mkVec(logic tv, int ti, int tw, logic av, int ai, int aw,
                                 logic lv, int li, logic [NWAY-1:0] m,
                                 logic ev, int ew, logic [LRU_W-1:0] el);
    vec_t v;
    v.tVld = tv; v.tIdx = IDX_W'(ti); v.tWay = WAY_W'(tw);
    v.aVld = av; v.aIdx = IDX_W'(ai); v.aWay = WAY_W'(aw);
    v.lVld = lv; v.lIdx = IDX_W'(li); v.mask = m;
    v.eVld = ev; v.eWay = WAY_W'(ew); v.eLru = el;
    return v;
  endfunction

  // Reference model written straight from the heap-node description
  logic [LRU_W-1:0] mdl [NSET];

  function automatic logic [LRU_W-1:0] mdlMark(input logic [LRU_W-1:0] t, input int w);
    int n;
    int b;
    n = 1;
    for (int lv = 0; lv < WAY_W; lv++) begin
      b = (w >> (WAY_W - 1 - lv)) & 1;
      t[3'(n - 1)] = (b == 0);
      n = 2 * n + b;
    end
    return t;
  endfunction

  function automatic int mdlVictim(input logic [LRU_W-1:0] t, input logic [NWAY-1:0] m);
    int n;
    int w;
    int b;
    if (m != '0) begin
      for (int i = NWAY - 1; i >= 0; i--) if ((m >> i) & 1) w = i;
      return w;
    end
    n = 1;
    w = 0;
    for (int lv = 0; lv < WAY_W; lv++) begin
      b = t[3'(n - 1)] ? 1 : 0;
      w = (w << 1) | b;
      n = 2 * n + b;
    end
    return w;
  endfunction

  task automatic applyStimulus(input vec_t v);
    touchVld = v.tVld; touchIdx = v.tIdx; touchWay = v.tWay;
    allocVld = v.aVld; allocIdx = v.aIdx; allocWay = v.aWay;
    lkpVld   = v.lVld; lkpIdx   = v.lIdx; lkpMask  = v.mask;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    touchVld = 0; touchIdx = '0; touchWay = '0;
    allocVld = 0; allocIdx = '0; allocWay = '0;
    lkpVld   = 0; lkpIdx   = '0; lkpMask  = '0;
  endtask

  vec_t vecs[15];

  initial begin
    logic             expVld;
    logic [WAY_W-1:0] expWay;
    logic [LRU_W-1:0] expLru;
    vec_t             r;

    // Row i expected values are the outputs after the edge that ends row i
    vecs[0]  = mkVec(0,0,0, 0,0,0, 1,3,8'h00,       1,0,7'b0000000);
    vecs[1]  = mkVec(1,3,0, 0,0,0, 0,0,8'h00,       0,0,7'b0000000);
    vecs[2]  = mkVec(0,0,0, 0,0,0, 1,3,8'h00,       1,4,7'b0001011);
    vecs[3]  = mkVec(1,5,5, 0,0,0, 0,0,8'h00,       0,4,7'b0001011);
    vecs[4]  = mkVec(0,0,0, 0,0,0, 1,5,8'h00,       1,0,7'b0000100);
    vecs[5]  = mkVec(0,0,0, 0,0,0, 1,6,8'h00,       1,0,7'b0000000);
    vecs[6]  = mkVec(1,2,5, 1,2,0, 1,2,8'h00,       1,2,7'b0001110);
    vecs[7]  = mkVec(0,0,0, 0,0,0, 1,2,8'h00,       1,2,7'b0001110);
    vecs[8]  = mkVec(0,0,0, 0,0,0, 1,3,8'b0110_0000,1,5,7'b0001011);
    vecs[9]  = mkVec(0,0,0, 0,0,0, 1,3,8'h00,       1,4,7'b0001011);
    vecs[10] = mkVec(0,0,0, 1,7,3, 1,7,8'h00,       1,4,7'b0000001);
    vecs[11] = mkVec(1,7,4, 1,8,7, 1,8,8'h00,       1,0,7'b0000000);
    vecs[12] = mkVec(0,0,0, 0,0,0, 1,7,8'h00,       1,0,7'b0100100);
    vecs[13] = mkVec(0,0,0, 0,0,0, 1,3,8'b1000_0001,1,0,7'b0001011);
    vecs[14] = mkVec(0,0,0, 0,0,0, 1,3,8'b1000_0000,1,7,7'b0001011);

    idleInputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.vld", int'(victimVld), 0);
    checkOutput("reset.way", int'(victimWay), 0);
    checkOutput("reset.lru", int'(victimLru), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.vld", i), int'(victimVld), int'(vecs[i].eVld));
      checkOutput($sformatf("vec%0d.way", i), int'(victimWay), int'(vecs[i].eWay));
      checkOutput($sformatf("vec%0d.lru", i), int'(victimLru), int'(vecs[i].eLru));
    end

    // Reset mid-operation with a lookup in flight
    @(negedge clk);
    idleInputs();
    lkpVld = 1; lkpIdx = 6'd3;
    @(posedge clk);
    #1;
    checkOutput("midrst.pre.vld", int'(victimVld), 1);
    checkOutput("midrst.pre.lru", int'(victimLru), 7'b0001011);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.async.vld", int'(victimVld), 0);
    checkOutput("midrst.async.way", int'(victimWay), 0);
    checkOutput("midrst.async.lru", int'(victimLru), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lkpVld = 0;
    @(posedge clk);
    #1;
    checkOutput("midrst.post.vld", int'(victimVld), 0);
    @(negedge clk);
    lkpVld = 1; lkpIdx = 6'd3;
    @(posedge clk);
    #1;
    checkOutput("midrst.clr.vld", int'(victimVld), 1);
    checkOutput("midrst.clr.way", int'(victimWay), 0);
    checkOutput("midrst.clr.lru", int'(victimLru), 0);

    // Random soak against the model; the DUT is fully cleared at this point
    for (int s = 0; s < NSET; s++) mdl[s] = '0;
    expVld = 1'b1; expWay = '0; expLru = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c == 5000) begin
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("soak.rst.vld", int'(victimVld), 0);
        checkOutput("soak.rst.way", int'(victimWay), 0);
        checkOutput("soak.rst.lru", int'(victimLru), 0);
        for (int s = 0; s < NSET; s++) mdl[s] = '0;
        expVld = 1'b0; expWay = '0; expLru = '0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      r.tVld = 1'($urandom_range(0, 1));
      r.aVld = 1'($urandom_range(0, 1));
      r.lVld = ($urandom_range(0, 3) != 0);
      r.tIdx = ($urandom_range(0, 3) != 0) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
      r.aIdx = ($urandom_range(0, 3) != 0) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
      r.lIdx = ($urandom_range(0, 3) != 0) ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
      r.tWay = WAY_W'($urandom);
      r.aWay = WAY_W'($urandom);
      r.mask = ($urandom_range(0, 3) == 0) ? NWAY'($urandom) : '0;
      applyStimulus(r);
      if (r.aVld) mdl[r.aIdx] = mdlMark(mdl[r.aIdx], int'(r.aWay));
      if (r.tVld) mdl[r.tIdx] = mdlMark(mdl[r.tIdx], int'(r.tWay));
      expVld = r.lVld;
      if (r.lVld) begin
        expLru = mdl[r.lIdx];
        expWay = WAY_W'(mdlVictim(mdl[r.lIdx], r.mask));
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("soak%0d.vld", c), int'(victimVld), int'(expVld));
      checkOutput($sformatf("soak%0d.way", c), int'(victimWay), int'(expWay));
      checkOutput($sformatf("soak%0d.lru", c), int'(victimLru), int'(expLru));
    end

    @(negedge clk);
    idleInputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
